// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage -- parametrised inter-stage pipeline buffer with a 2-entry
// skid register and valid/ready handshake on both sides.
//
// The main entry {m_data, m_ctrl} drives the outputs. The skid entry
// {s_data, s_ctrl} catches the one beat that can arrive while the registered
// in_ready is still high and downstream stalls. Flush squashes every held
// control field to CTRL_NOP but keeps the data fields, so the last PC stays
// visible to interrupt / return-address logic.
//
// Optional feature macro: PIPE_SKID_STATS_EN (adds stall_cnt / flush_cnt).
//
// Ports:
//   clk        stage clock; active edge chosen by NEG_EDGE (1 = falling)
//   reset      asynchronous, active-high
//   flush      synchronous squash, sampled on the active edge
//   in_valid   upstream has a beat
//   in_ready   stage can accept a beat (registered)
//   in_data    upstream data payload  [DATA_W]
//   in_ctrl    upstream control payload [CTRL_W]
//   out_valid  main entry holds a valid beat
//   out_ready  downstream accepts; 0 is a stall
//   out_data   main entry data [DATA_W]
//   out_ctrl   main entry control [CTRL_W]; CTRL_NOP whenever out_valid=0
//   stall_cnt  saturating count of stalled offers [STAT_W] (stats build only)
//   flush_cnt  saturating count of flushes [STAT_W] (stats build only)

module pipe_skid_stage #(
  parameter int                 DATA_W   = 64,
  parameter int                 CTRL_W   = 32,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = {CTRL_W{1'b0}},
  parameter bit                 NEG_EDGE = 1'b1,
  parameter int                 STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
`endif
);

  if (DATA_W < 1 || CTRL_W < 1 || STAT_W < 1) begin : g_bad_width
    $error("pipe_skid_stage: DATA_W, CTRL_W and STAT_W must all be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  // Every register in the stage runs off one effective clock, so the edge
  // selection lives in a single place and reset stays asynchronous.
  logic aclk;
  assign aclk = NEG_EDGE ? ~clk : clk;

  state_t            state, state_nx;
  logic [DATA_W-1:0] m_data, m_data_nx, s_data, s_data_nx;
  logic [CTRL_W-1:0] m_ctrl, m_ctrl_nx, s_ctrl, s_ctrl_nx;
  logic              in_ready_nx;
  logic              in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      m_data   <= '0;
      s_data   <= '0;
      m_ctrl   <= CTRL_NOP;
      s_ctrl   <= CTRL_NOP;
    end else begin
      state    <= state_nx;
      in_ready <= in_ready_nx;
      m_data   <= m_data_nx;
      s_data   <= s_data_nx;
      m_ctrl   <= m_ctrl_nx;
      s_ctrl   <= s_ctrl_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    m_data_nx = m_data;
    m_ctrl_nx = m_ctrl;
    s_data_nx = s_data;
    s_ctrl_nx = s_ctrl;
    if (flush) begin
      // Data is deliberately held; any in_fire this cycle is dropped.
      state_nx  = EMPTY;
      m_ctrl_nx = CTRL_NOP;
      s_ctrl_nx = CTRL_NOP;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nx  = ONE;
            m_data_nx = in_data;
            m_ctrl_nx = in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_data_nx = in_data;
            m_ctrl_nx = in_ctrl;
          end else if (in_fire) begin
            state_nx  = FULL;
            s_data_nx = in_data;
            s_ctrl_nx = in_ctrl;
          end else if (out_fire) begin
            state_nx  = EMPTY;
            m_ctrl_nx = CTRL_NOP;
          end
        end
        FULL: begin
          // in_ready is 0 here, so only the drain side can move.
          if (out_fire) begin
            state_nx  = ONE;
            m_data_nx = s_data;
            m_ctrl_nx = s_ctrl;
            s_ctrl_nx = CTRL_NOP;
          end
        end
        default: begin
          // Unused encoding 2'b10: fall back to a clean bubble.
          state_nx  = EMPTY;
          m_ctrl_nx = CTRL_NOP;
          s_ctrl_nx = CTRL_NOP;
        end
      endcase
    end
    // Registered ready: computed from where the FSM is going, so it is 0
    // exactly for the cycles spent in FULL.
    in_ready_nx = (state_nx != FULL);
  end

`ifdef PIPE_SKID_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && !flush) stall_cnt <= sat_inc(stall_cnt);
      if (flush)                           flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage. Two instances run side by side: dut_a uses
// NEG_EDGE=1 on clk, dut_b uses NEG_EDGE=0 on ~clk, so both should update on
// the falling edge of clk and match the same queue-based reference model.
module tb_pipe_skid_stage;
  localparam int DW = 64;
  localparam int CW = 32;
  localparam int SW = 16;
  localparam int VW = 2 + CW + DW;
  localparam logic [CW-1:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic clkb;
  logic reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [DW-1:0] a_out_data, b_out_data;
  logic [CW-1:0] a_out_ctrl, b_out_ctrl;
`ifdef PIPE_SKID_STATS_EN
  logic [SW-1:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  always #5 clk = ~clk;
  assign clkb = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .NEG_EDGE(1'b1), .STAT_W(SW)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl)
`ifdef PIPE_SKID_STATS_EN
    , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
  );

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .NEG_EDGE(1'b0), .STAT_W(SW)) dut_b (
    .clk(clkb), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl)
`ifdef PIPE_SKID_STATS_EN
    , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
  );

  logic [VW-1:0] obs_a, obs_b;
  assign obs_a = {a_out_valid, a_in_ready, a_out_ctrl, a_out_data};
  assign obs_b = {b_out_valid, b_in_ready, b_out_ctrl, b_out_data};

  int checks = 0;
  int errors = 0;

  // Reference model: the stage is a FIFO of capacity 2 whose head is shown
  // on the outputs; the data field keeps showing the last head once empty.
  logic [CW+DW-1:0] q[$];
  logic [DW-1:0]    hold_data;
  int               stall_m, flush_m;

  function automatic logic [VW-1:0] exp_vec();
    logic [CW-1:0] c;
    c = (q.size() > 0) ? q[0][CW+DW-1:DW] : NOP;
    return {q.size() > 0, q.size() < 2, c, hold_data};
  endfunction

  task automatic model_reset();
    q.delete();
    hold_data = '0;
    stall_m = 0;
    flush_m = 0;
  endtask

  task automatic model_edge(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                            input logic ordy, input logic fl);
    bit rdy, vld;
    rdy = (q.size() < 2);
    vld = (q.size() > 0);
    if (iv && !rdy && !fl && stall_m < (1 << SW) - 1) stall_m++;
    if (fl && flush_m < (1 << SW) - 1) flush_m++;
    if (fl) q.delete();
    else begin
      if (vld && ordy) void'(q.pop_front());
      if (iv && rdy) q.push_back({ic, id});
    end
    if (q.size() > 0) hold_data = q[0][DW-1:0];
  endtask

  // Drive one cycle of inputs, advance the model, and land 2 time units
  // after the active (falling) edge with inputs still held.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                      input logic ordy, input logic fl);
    in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy; flush = fl;
    model_edge(iv, id, ic, ordy, fl);
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [VW-1:0] rexp;
    rexp = {1'b0, 1'b1, NOP, {DW{1'b0}}};
    step(1'b1, 64'hAAAA, 32'h11, 1'b0, 1'b0);
    step(1'b1, 64'hBBBB, 32'h22, 1'b0, 1'b0);
    checks++;
    if (obs_a !== exp_vec()) begin errors++; $display("FAIL reset_prefill_a: got %h expected %h", obs_a, exp_vec()); end
    #1 reset = 1'b1;
    #1 model_reset();
    checks++;
    if (obs_a !== rexp) begin errors++; $display("FAIL reset_async_a: got %h expected %h", obs_a, rexp); end
    checks++;
    if (obs_b !== rexp) begin errors++; $display("FAIL reset_async_b: got %h expected %h", obs_b, rexp); end
`ifdef PIPE_SKID_STATS_EN
    checks++;
    if ({a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt} !== '0) begin
      errors++; $display("FAIL reset_stats: got %h %h expected 0 0", a_stall_cnt, a_flush_cnt);
    end
`endif
    @(negedge clk);
    #2 reset = 1'b0;
    checks++;
    if (obs_a !== rexp) begin errors++; $display("FAIL reset_release_a: got %h expected %h", obs_a, rexp); end
    step(1'b1, 64'hC0C0, 32'h33, 1'b0, 1'b0);
    checks++;
    if (obs_a !== exp_vec() || obs_b !== exp_vec()) begin
      errors++; $display("FAIL reset_first_edge: got %h / %h expected %h", obs_a, obs_b, exp_vec());
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), $urandom, 1'b1, 1'b0);
      checks++;
      if (obs_a !== exp_vec() || a_out_data !== DW'(i) || a_in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_a[%0d]: got %h expected %h", i, obs_a, exp_vec());
      end
      checks++;
      if (obs_b !== exp_vec()) begin errors++; $display("FAIL stream_b[%0d]: got %h expected %h", i, obs_b, exp_vec()); end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== exp_vec() || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: got %h expected %h", obs_a, exp_vec());
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 64'hA, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 64'hB, 32'hB2, 1'b0, 1'b0);
    checks++;
    if (obs_a !== exp_vec() || a_in_ready !== 1'b0 || a_out_data !== 64'hA) begin
      errors++; $display("FAIL bp_full_a: got %h expected %h", obs_a, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 64'hC, 32'hC3, 1'b0, 1'b0);
      checks++;
      if (obs_a !== exp_vec() || obs_b !== exp_vec()) begin
        errors++; $display("FAIL bp_stall[%0d]: got %h / %h expected %h", i, obs_a, obs_b, exp_vec());
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== exp_vec() || a_out_data !== 64'hB || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first_out: got %h expected %h", obs_a, exp_vec());
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== exp_vec() || obs_b !== exp_vec()) begin
      errors++; $display("FAIL bp_second_out: got %h / %h expected %h", obs_a, obs_b, exp_vec());
    end
`ifdef PIPE_SKID_STATS_EN
    checks++;
    if (a_stall_cnt !== SW'(stall_m) || b_stall_cnt !== SW'(stall_m)) begin
      errors++; $display("FAIL bp_stall_cnt: got %0d / %0d expected %0d", a_stall_cnt, b_stall_cnt, stall_m);
    end
`endif
  endtask

  task automatic test_flush();
    logic [VW-1:0] fexp;
    fexp = {1'b0, 1'b1, NOP, 64'h1234};
    step(1'b1, 64'h1234, 32'hA5, 1'b0, 1'b0);
    step(1'b1, 64'h5678, 32'hB6, 1'b0, 1'b0);
    step(1'b1, 64'h9999, 32'hC7, 1'b0, 1'b1);
    checks++;
    if (obs_a !== fexp || obs_a !== exp_vec()) begin
      errors++; $display("FAIL flush_a: got %h expected %h", obs_a, fexp);
    end
    checks++;
    if (obs_b !== fexp) begin errors++; $display("FAIL flush_b: got %h expected %h", obs_b, fexp); end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== fexp || obs_b !== fexp) begin
      errors++; $display("FAIL flush_no_deliver: got %h / %h expected %h", obs_a, obs_b, fexp);
    end
`ifdef PIPE_SKID_STATS_EN
    checks++;
    if (a_flush_cnt !== SW'(flush_m) || b_flush_cnt !== SW'(flush_m)) begin
      errors++; $display("FAIL flush_cnt: got %0d / %0d expected %0d", a_flush_cnt, b_flush_cnt, flush_m);
    end
`endif
  endtask

  task automatic test_edge_select();
    logic [VW-1:0] pre;
    pre = exp_vec();
    in_valid = 1'b1; in_data = 64'hE0E0; in_ctrl = 32'hE1; out_ready = 1'b0; flush = 1'b0;
    model_edge(1'b1, 64'hE0E0, 32'hE1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (obs_a !== pre || obs_b !== pre) begin
      errors++; $display("FAIL edge_inactive: got %h / %h expected %h", obs_a, obs_b, pre);
    end
    @(negedge clk);
    #2;
    checks++;
    if (obs_a !== exp_vec() || obs_b !== exp_vec()) begin
      errors++; $display("FAIL edge_active: got %h / %h expected %h", obs_a, obs_b, exp_vec());
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 100; i++) begin
      step(($urandom % 4) != 0, {$urandom, $urandom}, $urandom | 32'h100,
           ($urandom % 3) != 0, ($urandom % 25) == 0);
      checks++;
      if (obs_a !== exp_vec() || obs_b !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h / %h expected %h", i, obs_a, obs_b, exp_vec());
      end
      checks++;
      if (!a_out_valid && a_out_ctrl !== NOP) begin
        errors++; $display("FAIL random_nop[%0d]: got ctrl %h expected %h", i, a_out_ctrl, NOP);
      end
    end
`ifdef PIPE_SKID_STATS_EN
    checks++;
    if (a_stall_cnt !== SW'(stall_m) || a_flush_cnt !== SW'(flush_m)) begin
      errors++; $display("FAIL random_stats: got %0d %0d expected %0d %0d", a_stall_cnt, a_flush_cnt, stall_m, flush_m);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    model_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_edge_select();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised inter-stage pipeline buffer, the successor to the fixed-field stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Payload is split into a DATA field and a CTRL field. Stall is replaced by a valid/ready handshake.
- A 2-entry skid register lets upstream see a registered ready without losing a beat.
- Flush squashes all held control to a configurable NOP encoding.

Parameters:
- DATA_W, 64, width of the data payload (PC, operands, immediates); retained on flush.
- CTRL_W, 32, width of the control payload (write enables, ALU op, flag set/clr, jump selects).
- CTRL_NOP, {CTRL_W{1'b0}}, control value loaded on reset, flush and drain; encodes a bubble.
- NEG_EDGE, 1, 1 = registers update on falling clk edge (matches current pipeline); 0 = rising edge.
- STAT_W, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  stage clock; active edge selected by NEG_EDGE.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous squash, sampled on the active edge.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage can accept a beat; registered.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  main entry holds a valid beat.
- out_ready  in  1  downstream accepts; driving 0 is a stall.
- out_data  out  DATA_W  main entry data.
- out_ctrl  out  CTRL_W  main entry control; equals CTRL_NOP whenever out_valid=0.
- stall_cnt  out  STAT_W  optional feature only.
- flush_cnt  out  STAT_W  optional feature only.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_data and in_ctrl are sampled only on in_fire.
  - Upstream may deassert in_valid at any time.
- Storage: main entry {m_data, m_ctrl} drives the outputs; skid entry {s_data, s_ctrl}.
- States: EMPTY (00), ONE (01), FULL (11).
  - EMPTY:
    - in_fire -> ONE; main<=in.
    - Otherwise hold.
  - ONE:
    - in_fire & out_fire -> ONE; main<=in.
    - in_fire & !out_fire -> FULL; skid<=in.
    - !in_fire & out_fire -> EMPTY; m_ctrl<=CTRL_NOP, m_data held.
    - Otherwise hold.
  - FULL:
    - out_fire -> ONE; main<=skid, s_ctrl<=CTRL_NOP.
    - Otherwise hold.
    - in_fire is impossible in FULL (in_ready=0).
- Output derivation:
  - out_valid = (state != EMPTY).
  - in_ready is registered and equals (next_state != FULL), so in_ready=0 exactly while in FULL.
- Latency:
  - 1 active edge from in_fire to out_valid when EMPTY.
  - Full throughput (1 beat/cycle) while out_ready=1.
  - Beats leave in acceptance order; none are lost or duplicated.
- Flush:
  - Priority: reset > flush > handshake.
  - state<=EMPTY; m_ctrl and s_ctrl <= CTRL_NOP; in_ready<=1.
  - m_data and s_data are held, so PC stays visible for interrupt/return-address logic.
  - An in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by downstream.
- Reset (async, any time, including in FULL):
  - state EMPTY; m_data, s_data = 0; m_ctrl, s_ctrl = CTRL_NOP.
  - Outputs: out_valid=0, out_data=0, out_ctrl=CTRL_NOP, in_ready=1.
  - On reset release, the first active edge behaves as EMPTY.
- Clock edge: NEG_EDGE=1 uses falling edge, NEG_EDGE=0 uses rising edge. Reset stays asynchronous in both modes.
- Widths:
  - No arithmetic on the payload.
  - DATA_W>=1 and CTRL_W>=1 are required; elaboration error otherwise.

Optional Feature:
- Macro: PIPE_SKID_STATS_EN.
- Defined:
  - stall_cnt increments each active edge with in_valid & !in_ready & !flush.
  - flush_cnt increments each active edge with flush=1.
  - Both counters saturate at all-ones.
  - Both are cleared by reset only; flush does not clear them.
- Undefined: stall_cnt and flush_cnt ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset in FULL state, then release -> out_valid=0, out_ctrl=CTRL_NOP, out_data=0, in_ready=1; stats (if enabled) =0.
2. out_ready=1, stream data 1..8 one per cycle -> out_data 1..8 in order, each 1 edge after acceptance; in_ready stays 1.
3. Push A, B with out_ready=0 -> FULL, in_ready=0, out_data=A. Raise out_ready -> A then B delivered; in_ready=1 the edge after A leaves. stall_cnt counts the cycles with in_valid & !in_ready.
4. FULL with m_data=0x1234 and ctrl!=NOP, plus in_valid=1, assert flush -> out_valid=0, out_ctrl=CTRL_NOP, out_data=0x1234; the input beat is not delivered; flush_cnt=1.
5. ONE state, in_fire & out_fire every cycle for 100 cycles with random out_ready gaps -> scoreboard shows no loss or duplication, and out_ctrl=CTRL_NOP whenever out_valid=0.
6. Repeat tests 2-4 with NEG_EDGE=0 and NEG_EDGE=1 -> updates occur only on the selected edge.
